// File: rtl/pd_pkg.sv
// Shared widths, saturation limits and a signed-saturation helper for the PD math datapath.
package pd_pkg;

  localparam int ERR_W   = 10;
  localparam int DIFF_W  = 7;
  localparam int DTERM_W = 12;

  localparam int ERR_MAX  = 511;
  localparam int ERR_MIN  = -512;
  localparam int DIFF_MAX = 63;
  localparam int DIFF_MIN = -64;

  // Clamp a 17-bit signed value into [lo, hi]; caller keeps the low bits it needs.
  function automatic logic signed [16:0] sat_signed(input logic signed [16:0] v,
                                                    input int lo, input int hi);
    int vi;
    vi = int'(v);
    if (vi > hi)      return 17'(hi);
    else if (vi < lo) return 17'(lo);
    else              return v;
  endfunction

endpackage

// File: rtl/pd_err_queue.sv
// Circular history of saturated errors; dout is the entry that will be overwritten next.
// Optional synchronous flush via clr when PD_QUEUE_FLUSH_EN is defined.
module pd_err_queue
  import pd_pkg::*;
#(
  parameter int DEPTH = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
`ifdef PD_QUEUE_FLUSH_EN
  input  logic                    clr,
`endif
  input  logic signed [ERR_W-1:0] din,
  output logic signed [ERR_W-1:0] dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic signed [ERR_W-1:0] mem [DEPTH];
  logic        [PTR_W-1:0] ptr;

  assign dout = mem[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end
`ifdef PD_QUEUE_FLUSH_EN
    // Flush overrides a coincident push so the queue ends all-zero.
    else if (clr) begin
      ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end
`endif
    else if (push) begin
      mem[ptr] <= din;
      if (ptr == PTR_W'(DEPTH - 1)) ptr <= '0;
      else                          ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pd_math.sv
// Two-stage PD term pipeline: saturated error capture, then P (5/8 gain) and D terms.
// Define PD_QUEUE_FLUSH_EN to add the clr_q history-flush input.
module pd_math
  import pd_pkg::*;
#(
  parameter int         D_QUEUE_DEPTH = 12,
  parameter logic [4:0] D_COEFF       = 5'd7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      vld,
`ifdef PD_QUEUE_FLUSH_EN
  input  logic                      clr_q,
`endif
  input  logic signed [15:0]        desired,
  input  logic signed [15:0]        actual,
  output logic signed [ERR_W-1:0]   pterm,
  output logic signed [DTERM_W-1:0] dterm,
  output logic                      out_vld
);

  logic signed [16:0]          err_full;
  logic signed [16:0]          err_sat17;
  logic signed [ERR_W-1:0]     err_q;
  logic                        stage1_vld;
  logic signed [ERR_W-1:0]     q_dout;
  logic signed [ERR_W-1:0]     prev_err;
  logic signed [ERR_W:0]       diff;
  logic signed [16:0]          diff_sat17;
  logic signed [DIFF_W-1:0]    diff_s;
  logic signed [5:0]           coeff;
  logic signed [DIFF_W+5:0]    prod;

  always_comb begin
    err_full   = {actual[15], actual} - {desired[15], desired};
    err_sat17  = sat_signed(err_full, ERR_MIN, ERR_MAX);
`ifdef PD_QUEUE_FLUSH_EN
    prev_err   = clr_q ? '0 : q_dout;
`else
    prev_err   = q_dout;
`endif
    diff       = {err_q[ERR_W-1], err_q} - {prev_err[ERR_W-1], prev_err};
    diff_sat17 = sat_signed({{(17-ERR_W-1){diff[ERR_W]}}, diff}, DIFF_MIN, DIFF_MAX);
    diff_s     = diff_sat17[DIFF_W-1:0];
    coeff      = {1'b0, D_COEFF};
    prod       = (DIFF_W+6)'(diff_s) * (DIFF_W+6)'(coeff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q      <= '0;
      stage1_vld <= 1'b0;
    end else begin
      stage1_vld <= vld;
      if (vld) err_q <= err_sat17[ERR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pterm   <= '0;
      dterm   <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= stage1_vld;
      if (stage1_vld) begin
        pterm <= (err_q >>> 1) + (err_q >>> 3);
        dterm <= prod[DTERM_W-1:0];
      end
    end
  end

  pd_err_queue #(
    .DEPTH (D_QUEUE_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stage1_vld),
`ifdef PD_QUEUE_FLUSH_EN
    .clr   (clr_q),
`endif
    .din   (err_q),
    .dout  (q_dout)
  );

endmodule
